// File: rtl/rlc_enc.sv
// Run-length encoder: 4 elements/input word, 3 (run,level) pairs per 64-bit output word; element k lands k+1 cycles after accept.
// Backpressure: enc_valid & ~dram_ready freezes the whole encoder; bypass mode is a zero-latency wire path.
module rlc_enc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enc_bypass_en,
  input  logic        core_valid,
  input  logic        core_last,
  input  logic [63:0] core_data,
  output logic        enc_ready,
  input  logic        dram_ready,
  output logic        enc_valid,
  output logic        enc_last,
  output logic [63:0] enc_data,
  output logic [15:0] enc_word_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, FLUSH = 2'd2} state_t;

  typedef struct packed {
    logic [4:0]  run;
    logic [15:0] level;
  } pair_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  slot_cnt_q, slot_cnt_d;
  logic [4:0]  zcnt_q, zcnt_d;
  pair_t [2:0] slot_q, slot_d, slot_w;
  logic [63:0] hold_data_q, hold_data_d;
  logic        hold_last_q, hold_last_d;
  logic [63:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic        new_tensor_q, new_tensor_d;
  logic [15:0] word_cnt_q, word_cnt_d;

  logic        stall, out_hs, accept, wr_en, flush_fire;
  pair_t       wr_pair;
  logic [15:0] elem;

  assign stall  = out_valid_q & ~dram_ready;
  assign out_hs = out_valid_q & dram_ready;
  assign elem   = hold_data_q[{idx_q, 4'b0000} +: 16];

  always_comb begin
    if (enc_bypass_en) begin
      enc_ready = dram_ready;
    end else begin
      enc_ready = rst_n & ((state_q == IDLE) |
                  ((state_q == SCAN) & (idx_q == 2'd3) & ~stall & ~hold_last_q));
    end
  end

  assign accept = ~enc_bypass_en & core_valid & enc_ready;

  assign enc_valid    = enc_bypass_en ? core_valid : out_valid_q;
  assign enc_last     = enc_bypass_en ? core_last  : out_last_q;
  assign enc_data     = enc_bypass_en ? core_data  : out_data_q;
  assign enc_word_cnt = word_cnt_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    zcnt_d       = zcnt_q;
    slot_d       = slot_q;
    slot_cnt_d   = slot_cnt_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q & ~dram_ready;
    out_last_d   = out_last_q & ~dram_ready;
    new_tensor_d = new_tensor_q;
    word_cnt_d   = out_hs ? word_cnt_q + 16'd1 : word_cnt_q;
    wr_en        = 1'b0;
    wr_pair      = '0;
    flush_fire   = 1'b0;
    slot_w       = slot_q;

    case (state_q)
      SCAN: begin
        if (!stall) begin
          if (elem != 16'd0) begin
            wr_en         = 1'b1;
            wr_pair.run   = zcnt_q;
            wr_pair.level = elem;
            zcnt_d        = 5'd0;
          end else if (zcnt_q == 5'd31) begin
            // 32nd consecutive zero: a (31,0) pair absorbs the whole run
            wr_en         = 1'b1;
            wr_pair.run   = 5'd31;
            zcnt_d        = 5'd0;
          end else begin
            zcnt_d = zcnt_q + 5'd1;
          end
          if (idx_q == 2'd3) begin
            state_d = hold_last_q ? FLUSH : IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      FLUSH: begin
        if (!stall) begin
          if (out_last_q) begin
            // final word is handshaking this cycle
            state_d      = IDLE;
            new_tensor_d = 1'b1;
          end else begin
            flush_fire = 1'b1;
            if (zcnt_q != 5'd0) begin
              wr_en       = 1'b1;
              wr_pair.run = zcnt_q;
              zcnt_d      = 5'd0;
            end
          end
        end
      end
      default: ;
    endcase

    if (wr_en) begin
      case (slot_cnt_q)
        2'd0:    slot_w[0] = wr_pair;
        2'd1:    slot_w[1] = wr_pair;
        default: slot_w[2] = wr_pair;
      endcase
    end

    if (flush_fire) begin
      out_data_d  = {slot_w[0], slot_w[1], slot_w[2], 1'b1};
      out_valid_d = 1'b1;
      out_last_d  = 1'b1;
      slot_d      = '0;
      slot_cnt_d  = 2'd0;
    end else if (wr_en) begin
      if (slot_cnt_q == 2'd2) begin
        out_data_d  = {slot_w[0], slot_w[1], slot_w[2], 1'b0};
        out_valid_d = 1'b1;
        out_last_d  = 1'b0;
        slot_d      = '0;
        slot_cnt_d  = 2'd0;
      end else begin
        slot_d     = slot_w;
        slot_cnt_d = slot_cnt_q + 2'd1;
      end
    end

    // accept overrides the idx-3 exit so back-to-back words stay in SCAN
    if (accept) begin
      hold_data_d = core_data;
      hold_last_d = core_last;
      idx_d       = 2'd0;
      state_d     = SCAN;
      if (new_tensor_q) begin
        word_cnt_d   = 16'd0;
        new_tensor_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      zcnt_q       <= 5'd0;
      slot_q       <= '0;
      slot_cnt_q   <= 2'd0;
      hold_data_q  <= 64'd0;
      hold_last_q  <= 1'b0;
      out_data_q   <= 64'd0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      new_tensor_q <= 1'b1;
      word_cnt_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      zcnt_q       <= zcnt_d;
      slot_q       <= slot_d;
      slot_cnt_q   <= slot_cnt_d;
      hold_data_q  <= hold_data_d;
      hold_last_q  <= hold_last_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      new_tensor_q <= new_tensor_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

endmodule

// File: doc/rlc_enc.md
RLC_ENC -- requirements
Module: rlc_enc

Interface
REQ-001 SHALL have the following ports, clock and reset first:
  clk  input  1  single clock; all logic on rising edge
  rst_n  input  1  synchronous, active-low reset
  enc_bypass_en  input  1  1 = pass core stream to DRAM unencoded; changed only while idle
  core_valid  input  1  core output word valid
  core_last  input  1  final word of a tensor/tile
  core_data  input  64  four 16-bit elements; element k = core_data[16k+15:16k], element 0 processed first
  enc_ready  output  1  rlc_enc accepts core word this cycle
  dram_ready  input  1  DRAM write side accepts enc word
  enc_valid  output  1  encoded word valid
  enc_last  output  1  final encoded word of the tensor
  enc_data  output  64  packed word: run_0[63:59] level_0[58:43] run_1[42:38] level_1[37:22] run_2[21:17] level_2[16:1] term[0]
  enc_word_cnt  output  16  encoded words issued for the current tensor
REQ-002 SHALL use one clock, clk; reset rst_n is synchronous and active-low.

Function
REQ-003 SHALL encode each element as a (run, level) pair: run = zeros since the previous pair (0..31), level = nonzero value; one pair represents run+1 elements.
REQ-004 SHALL, for a zero element while the zero counter equals 31, emit pair (31, 0) and clear the counter; the pair represents 32 zeros.
REQ-005 SHALL fill slots 0, 1, 2 in order; a word is complete when slot 2 is written, and it is then registered to enc_data with enc_valid=1 and term=0.
REQ-006 SHALL implement the FSM IDLE -> SCAN -> (IDLE | FLUSH) -> IDLE.
  IDLE: waits for the core handshake.
  SCAN: processes one element per cycle, index 0..3.
  FLUSH: terminates the tensor.
REQ-007 SHALL assert enc_ready in IDLE, and in SCAN at index 3 when not stalled and the held word has core_last=0; this gives 4 cycles per input word sustained.
REQ-008 SHALL capture core_data/core_last on core_valid & enc_ready, and process element k in the (k+1)th cycle after acceptance, absent stalls.
REQ-009 SHALL stall on enc_valid & ~dram_ready, freezing FSM, element index, zero counter and slots; enc_data and enc_valid SHALL be held stable.
REQ-010 SHALL, on enc_valid & dram_ready, clear the slots and allow a slot write into the fresh word in the same cycle.
REQ-011 SHALL, in FLUSH with zero counter z>0, write pair (z, 0); unused slots SHALL be run=0, level=0.
REQ-012 SHALL, in FLUSH, output the current word with term=1 and enc_last=1, even when no slot is filled (enc_data=0x0000_0000_0000_0001).
REQ-013 SHALL, if slots are full when FLUSH needs a slot, first issue the full word with term=0, then write the pair into the next word.
REQ-014 SHALL return to IDLE after the enc_last handshake, with zero counter and slots cleared.
REQ-015 SHALL increment enc_word_cnt on each encoded word handshake, hold it after enc_last, and clear it on the first accepted word of the next tensor; it wraps at 16 bits.
REQ-016 SHALL, in bypass: enc_valid=core_valid, enc_data=core_data, enc_last=core_last, enc_ready=dram_ready, with zero latency; the encoder state SHALL stay in IDLE.
REQ-017 SHALL treat run arithmetic as 5-bit unsigned; the zero counter SHALL never exceed 31.

Reset
REQ-018 SHALL, with rst_n=0 at a clk edge, return to IDLE with the following cleared: slots, zero counter, element index, enc_word_cnt=0, enc_valid=0, enc_last=0, enc_data=0.
REQ-019 SHALL hold enc_ready=0 while rst_n=0, outside bypass.
REQ-020 SHALL discard any partially encoded word on reset mid-tensor; no enc_valid SHALL be asserted in the cycle after reset.

Verification
REQ-021 SHALL cover: one last word with elements 0x0005,0,0,0x0007 and dram_ready=1 -> single word 0x0000_2880_01C0_0001, enc_last=1, enc_word_cnt=1, enc_valid 6 cycles after acceptance.
REQ-022 SHALL cover: 9 all-zero words, last on the 9th -> single word 0xF800_0100_0000_0001, i.e. pairs (31,0),(4,0), term=1.
REQ-023 SHALL cover: 3 last-terminated words, all elements nonzero -> 4 full words with term=0, then 0x0000_0000_0000_0001 with enc_last=1; enc_word_cnt=5.
REQ-024 SHALL cover: 4 words, all nonzero, with dram_ready low for 20 cycles then random -> 6 words in order, data stable under stall, last word with 1 pair and term=1.
REQ-025 SHALL cover: enc_bypass_en=1 with random core traffic -> enc_data/enc_valid/enc_last equal the core signals each cycle, and enc_ready=dram_ready.
REQ-026 SHALL cover: rst_n low for 1 cycle during SCAN of word 2 -> IDLE next cycle, enc_valid=0, enc_word_cnt=0, and the next tensor encodes correctly.
